// File: rtl/sram_arbiter.sv
// Two-client round-robin arbiter and controller for a shared 1M x 16 asynchronous SRAM.
// Each granted request holds the SRAM pins for ACCESS_CYCLES cycles, then pulses that client's ack.
module sram_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_c0_req,
    input  logic [19:0] i_c0_addr,
    input  logic        i_c0_we_n,
    input  logic [15:0] i_c0_wdata,
    output logic        o_c0_ack,
    output logic [15:0] o_c0_rdata,
    input  logic        i_c1_req,
    input  logic [19:0] i_c1_addr,
    input  logic        i_c1_we_n,
    input  logic [15:0] i_c1_wdata,
    output logic        o_c1_ack,
    output logic [15:0] o_c1_rdata,
    output logic [19:0] o_SRAM_ADDR,
    inout  wire  [15:0] io_SRAM_DQ,
    output logic        o_SRAM_WE_N,
    output logic        o_SRAM_CE_N,
    output logic        o_SRAM_OE_N,
    output logic        o_SRAM_LB_N,
    output logic        o_SRAM_UB_N
);
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_grant;
    logic                w_gsel;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_sel_we_n;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_dir_n;
    logic                w_we_n_nxt;
    logic                w_ce_n_nxt;
    logic                w_oe_n_nxt;
    logic                w_dq_oe_nxt;
    logic                w_ack0_nxt;
    logic                w_ack1_nxt;

    logic                r_gsel;
    logic                r_last_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we_n;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                r_sram_we_n;
    logic                r_sram_ce_n;
    logic                r_sram_oe_n;
    logic                r_dq_oe;
    logic                r_ack0;
    logic                r_ack1;

    // Selected client's request fields
    assign w_sel_addr  = w_gsel ? i_c1_addr  : i_c0_addr;
    assign w_sel_we_n  = w_gsel ? i_c1_we_n  : i_c0_we_n;
    assign w_sel_wdata = w_gsel ? i_c1_wdata : i_c0_wdata;
    assign w_dir_n     = w_grant ? w_sel_we_n : r_we_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // On a tie the client that did not win last time is granted
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_gsel       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_c0_req || i_c1_req) begin
                    w_grant      = 1'b1;
                    w_gsel       = (i_c0_req && i_c1_req) ? ~r_last_grant : i_c1_req;
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Pin and ack values for the state being entered, registered below
    always_comb begin
        w_we_n_nxt  = 1'b1;
        w_ce_n_nxt  = 1'b1;
        w_oe_n_nxt  = 1'b1;
        w_dq_oe_nxt = 1'b0;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
        case (w_state_next)
            ST_ACCESS: begin
                w_ce_n_nxt = 1'b0;
                if (w_dir_n) begin
                    w_oe_n_nxt = 1'b0;
                end else begin
                    w_we_n_nxt  = 1'b0;
                    w_dq_oe_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                w_ack0_nxt = ~r_gsel;
                w_ack1_nxt = r_gsel;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gsel       <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_we_n       <= 1'b1;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            if (w_grant) begin
                r_gsel       <= w_gsel;
                r_last_grant <= w_gsel;
                r_cnt        <= CNT_LOAD;
                r_addr       <= w_sel_addr;
                r_we_n       <= w_sel_we_n;
                r_wdata      <= w_sel_wdata;
            end else if (r_state == ST_ACCESS && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            // Capture read data on the last cycle of the access
            if (r_state == ST_ACCESS && r_cnt == '0 && r_we_n) begin
                if (r_gsel) begin
                    r_rdata1 <= io_SRAM_DQ;
                end else begin
                    r_rdata0 <= io_SRAM_DQ;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sram_we_n <= 1'b1;
            r_sram_ce_n <= 1'b1;
            r_sram_oe_n <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
        end else begin
            r_sram_we_n <= w_we_n_nxt;
            r_sram_ce_n <= w_ce_n_nxt;
            r_sram_oe_n <= w_oe_n_nxt;
            r_dq_oe     <= w_dq_oe_nxt;
            r_ack0      <= w_ack0_nxt;
            r_ack1      <= w_ack1_nxt;
        end
    end

    assign io_SRAM_DQ  = r_dq_oe ? r_wdata : {DATA_W{1'bz}};
    assign o_SRAM_ADDR = r_addr;
    assign o_SRAM_WE_N = r_sram_we_n;
    assign o_SRAM_CE_N = r_sram_ce_n;
    assign o_SRAM_OE_N = r_sram_oe_n;
    assign o_SRAM_LB_N = 1'b0;
    assign o_SRAM_UB_N = 1'b0;
    assign o_c0_ack    = r_ack0;
    assign o_c1_ack    = r_ack1;
    assign o_c0_rdata  = r_rdata0;
    assign o_c1_rdata  = r_rdata1;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three instances (2, 1 and 4 access cycles) each with an SRAM array,
// checked every cycle against a transaction-level model plus directed literal expectations.
`timescale 1ns/1ps
module tb_sram_arbiter;
    localparam int NI = 3;

    logic        clk;
    logic        rst_n;
    logic        req   [NI][2];
    logic [19:0] addr  [NI][2];
    logic        we_n  [NI][2];
    logic [15:0] wdata [NI][2];
    logic        ack   [NI][2];
    logic [15:0] rdata [NI][2];
    logic [19:0] s_addr [NI];
    logic        s_we_n [NI];
    logic        s_ce_n [NI];
    logic        s_oe_n [NI];
    logic        s_lb_n [NI];
    logic        s_ub_n [NI];
    logic [15:0] s_dq   [NI];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ac_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned AC = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        wire  [15:0] dq;
        logic [15:0] mem [0:1048575];

        sram_arbiter #(.ACCESS_CYCLES(AC)) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_c0_req    (req[g][0]),
            .i_c0_addr   (addr[g][0]),
            .i_c0_we_n   (we_n[g][0]),
            .i_c0_wdata  (wdata[g][0]),
            .o_c0_ack    (ack[g][0]),
            .o_c0_rdata  (rdata[g][0]),
            .i_c1_req    (req[g][1]),
            .i_c1_addr   (addr[g][1]),
            .i_c1_we_n   (we_n[g][1]),
            .i_c1_wdata  (wdata[g][1]),
            .o_c1_ack    (ack[g][1]),
            .o_c1_rdata  (rdata[g][1]),
            .o_SRAM_ADDR (s_addr[g]),
            .io_SRAM_DQ  (dq),
            .o_SRAM_WE_N (s_we_n[g]),
            .o_SRAM_CE_N (s_ce_n[g]),
            .o_SRAM_OE_N (s_oe_n[g]),
            .o_SRAM_LB_N (s_lb_n[g]),
            .o_SRAM_UB_N (s_ub_n[g])
        );

        // Asynchronous SRAM: drives on read, stores while WE_N is low
        assign dq = (!s_ce_n[g] && !s_oe_n[g] && s_we_n[g]) ? mem[s_addr[g]] : 16'hzzzz;
        always @(posedge clk) begin
            if (!s_ce_n[g] && !s_we_n[g]) mem[s_addr[g]] <= dq;
        end
        assign s_dq[g] = dq;
    end

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h", nm, g, act, exp);
        end
    endtask

    // Transaction model: phase 0 idle, 1..AC access, AC+1 ack cycle
    int          m_ph   [NI];
    int          m_who  [NI];
    logic        m_last [NI];
    logic [19:0] m_addr [NI];
    logic        m_wen  [NI];
    logic [15:0] m_wd   [NI];
    logic [15:0] m_rd   [NI][2];
    logic [15:0] m_mem  [int];

    always @(negedge clk) begin : p_cmp
        int ac;
        int ph;
        int w;
        int key;
        for (int g = 0; g < NI; g++) begin
            ac = ac_of(g);
            if (!rst_n) begin
                m_ph[g]    = 0;
                m_last[g]  = 1'b1;
                m_rd[g][0] = 16'h0;
                m_rd[g][1] = 16'h0;
                chk("rst_addr", g, 32'(s_addr[g]), 32'h0);
            end
            ph = m_ph[g];
            chk("lb_n", g, 32'(s_lb_n[g]), 32'h0);
            chk("ub_n", g, 32'(s_ub_n[g]), 32'h0);
            if (ph >= 1 && ph <= ac) begin
                chk("ce_n", g, 32'(s_ce_n[g]), 32'h0);
                chk("oe_n", g, 32'(s_oe_n[g]), 32'(m_wen[g] ? 0 : 1));
                chk("we_n", g, 32'(s_we_n[g]), 32'(m_wen[g] ? 1 : 0));
                chk("addr", g, 32'(s_addr[g]), 32'(m_addr[g]));
                if (!m_wen[g]) chk("dq_wdata", g, 32'(s_dq[g]), 32'(m_wd[g]));
            end else begin
                chk("ce_n_idle", g, 32'(s_ce_n[g]), 32'h1);
                chk("oe_n_idle", g, 32'(s_oe_n[g]), 32'h1);
                chk("we_n_idle", g, 32'(s_we_n[g]), 32'h1);
                if (ph == ac + 1) chk("addr_hold", g, 32'(s_addr[g]), 32'(m_addr[g]));
            end
            chk("ack0", g, 32'(ack[g][0]), 32'((ph == ac + 1 && m_who[g] == 0) ? 1 : 0));
            chk("ack1", g, 32'(ack[g][1]), 32'((ph == ac + 1 && m_who[g] == 1) ? 1 : 0));
            chk("rdata0", g, 32'(rdata[g][0]), 32'(m_rd[g][0]));
            chk("rdata1", g, 32'(rdata[g][1]), 32'(m_rd[g][1]));
            if (rst_n) begin
                if (ph == 0) begin
                    if (req[g][0] || req[g][1]) begin
                        w = (req[g][0] && req[g][1]) ? (m_last[g] ? 0 : 1) : (req[g][1] ? 1 : 0);
                        m_who[g]  = w;
                        m_last[g] = (w == 1);
                        m_addr[g] = addr[g][w];
                        m_wen[g]  = we_n[g][w];
                        m_wd[g]   = wdata[g][w];
                        m_ph[g]   = 1;
                    end
                end else if (ph <= ac) begin
                    if (ph == ac) begin
                        key = g * 1048576 + int'(m_addr[g]);
                        if (m_wen[g]) m_rd[g][m_who[g]] = m_mem.exists(key) ? m_mem[key] : 16'h0;
                        else m_mem[key] = m_wd[g];
                    end
                    m_ph[g] = ph + 1;
                end else begin
                    m_ph[g] = 0;
                end
            end
        end
    end

    task automatic wait_ack(input int g, input int c, output int n, output int we_lo,
                            output int oe_lo, output bit seen);
        n = 0; we_lo = 0; oe_lo = 0; seen = 1'b0;
        while (n < 60) begin
            @(negedge clk);
            if (ack[g][c]) begin
                seen = 1'b1;
                break;
            end
            if (!s_we_n[g]) we_lo++;
            if (!s_oe_n[g]) oe_lo++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Single-client access, called one time unit after a rising edge in an idle cycle
    task automatic do_access(input int g, input int c, input logic [19:0] a, input logic wen,
                             input logic [15:0] wd, input int exp_lat, output logic [15:0] rd);
        int n, we_lo, oe_lo;
        bit seen;
        addr[g][c] = a; we_n[g][c] = wen; wdata[g][c] = wd; req[g][c] = 1'b1;
        wait_ack(g, c, n, we_lo, oe_lo, seen);
        chk("ack_seen", g, 32'(seen), 32'h1);
        chk("latency", g, 32'(n), 32'(exp_lat));
        chk("we_low_cycles", g, 32'(we_lo), 32'(wen ? 0 : exp_lat - 1));
        chk("oe_low_cycles", g, 32'(oe_lo), 32'(wen ? exp_lat - 1 : 0));
        rd = rdata[g][c];
        @(posedge clk); #1;
        req[g][c] = 1'b0;
    endtask

    initial begin
        int n, we_lo, oe_lo, found;
        int cnt [2];
        bit seen;
        logic [15:0] rd;
        for (int g = 0; g < NI; g++) begin
            for (int c = 0; c < 2; c++) begin
                req[g][c] = 1'b0; addr[g][c] = '0; we_n[g][c] = 1'b1; wdata[g][c] = '0;
            end
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Startup with both clients requesting during reset
        addr[0][0] = 20'h00003; we_n[0][0] = 1'b0; wdata[0][0] = 16'h1111; req[0][0] = 1'b1;
        addr[0][1] = 20'h00100; we_n[0][1] = 1'b0; wdata[0][1] = 16'h7777; req[0][1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ce_n", 0, 32'(s_ce_n[0]), 32'h1);
        chk("rst_we_n", 0, 32'(s_we_n[0]), 32'h1);
        chk("rst_ack0", 0, 32'(ack[0][0]), 32'h0);
        chk("rst_ack1", 0, 32'(ack[0][1]), 32'h0);
        @(posedge clk); #2 rst_n = 1'b1;
        wait_ack(0, 0, n, we_lo, oe_lo, seen);
        chk("first_grant_c0", 0, 32'(seen), 32'h1);
        chk("first_latency", 0, 32'(n), 32'd3);
        @(posedge clk); #1 req[0][0] = 1'b0;
        wait_ack(0, 1, n, we_lo, oe_lo, seen);
        chk("second_grant_c1", 0, 32'(seen), 32'h1);
        chk("second_latency", 0, 32'(n), 32'd3);
        @(posedge clk); #1 req[0][1] = 1'b0;

        // Client 0 write then read back
        do_access(0, 0, 20'h00010, 1'b0, 16'h1234, 3, rd);
        do_access(0, 0, 20'h00010, 1'b1, 16'h0000, 3, rd);
        chk("c0_read_0x10", 0, 32'(rd), 32'h1234);

        // Client 1 at top address; client 0 rdata must not move
        do_access(0, 1, 20'hFFFFF, 1'b0, 16'hBEEF, 3, rd);
        do_access(0, 1, 20'hFFFFF, 1'b1, 16'h0000, 3, rd);
        chk("c1_read_top", 0, 32'(rd), 32'hBEEF);
        chk("c0_rdata_kept", 0, 32'(rdata[0][0]), 32'h1234);

        // Reset in the second access cycle of a write, then the held request completes
        addr[0][0] = 20'h00020; we_n[0][0] = 1'b0; wdata[0][0] = 16'h5555; req[0][0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_we_low", 0, 32'(s_we_n[0]), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("abort_ce_n", 0, 32'(s_ce_n[0]), 32'h1);
        chk("abort_we_n", 0, 32'(s_we_n[0]), 32'h1);
        chk("abort_oe_n", 0, 32'(s_oe_n[0]), 32'h1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_ack(0, 0, n, we_lo, oe_lo, seen);
        chk("reissue_ack", 0, 32'(seen), 32'h1);
        chk("reissue_latency", 0, 32'(n), 32'd3);
        chk("reissue_we_cycles", 0, 32'(we_lo), 32'd2);
        @(posedge clk); #1 req[0][0] = 1'b0;
        chk("mem_0x20", 0, 32'(g_dut[0].mem[20'h00020]), 32'h5555);

        // Both clients streaming writes after a fresh reset
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        cnt[0] = 0; cnt[1] = 0;
        addr[0][0] = 20'h00000; we_n[0][0] = 1'b0; wdata[0][0] = 16'hA000; req[0][0] = 1'b1;
        addr[0][1] = 20'h80000; we_n[0][1] = 1'b0; wdata[0][1] = 16'hB000; req[0][1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n = 0; found = -1;
            while (n < 60) begin
                @(negedge clk);
                if (ack[0][0]) found = 0;
                else if (ack[0][1]) found = 1;
                if (found >= 0) break;
                @(posedge clk); #1;
                n++;
            end
            chk("fair_order", 0, 32'(found), 32'(i % 2));
            chk("ack_spacing", 0, 32'(n), 32'd3);
            if (found < 0) break;
            cnt[found]++;
            @(posedge clk); #1;
            if (cnt[found] < 4) begin
                addr[0][found]  = (found == 1 ? 20'h80000 : 20'h00000) + 20'(cnt[found]);
                wdata[0][found] = (found == 1 ? 16'hB000 : 16'hA000) + 16'(cnt[found]);
            end else begin
                req[0][found] = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk("stream_mem_c0", 0, 32'(g_dut[0].mem[20'(i)]), 32'(16'hA000 + 16'(i)));
            chk("stream_mem_c1", 0, 32'(g_dut[0].mem[20'h80000 + 20'(i)]), 32'(16'hB000 + 16'(i)));
        end

        // One-cycle and four-cycle access variants
        do_access(1, 0, 20'h00ABC, 1'b0, 16'hCAFE, 2, rd);
        do_access(1, 0, 20'h00ABC, 1'b1, 16'h0000, 2, rd);
        chk("ac1_read", 1, 32'(rd), 32'hCAFE);
        do_access(2, 1, 20'h12345, 1'b0, 16'h0F0F, 5, rd);
        do_access(2, 1, 20'h12345, 1'b1, 16'h0000, 5, rd);
        chk("ac4_read", 2, 32'(rd), 32'h0F0F);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
